// File: rtl/ide_disk_model.sv
// ide_disk_model
//   Device side of an IDE/ATA PIO bus. It emulates a single LBA disk whose
//   sector data lives in a word-addressed backing store. It implements the
//   ATA task file plus READ SECTORS (8'h20) and WRITE SECTORS (8'h30). Every
//   other command aborts.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   ide_dior, ide_diow     host read / write strobes (active-low)
//   ide_cs[1:0]            chip selects; task file decoded only when 2'b10
//   ide_da[2:0]            task file register address
//   ide_data_in[15:0]      host write data
//   ide_data_out[15:0]     registered device read data
//   ide_data_oe            registered, high while a decoded read is active
//   mem_addr               {lba[LBA_BITS-1:0], word_idx[7:0]}
//   mem_rd / mem_wr        backing-store request, held until mem_done
//   mem_wdata[15:0]        backing-store write data
//   mem_rdata[15:0]        backing-store read data, valid with mem_done
//   mem_done               one-cycle completion pulse
module ide_disk_model #(
   parameter int LBA_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ide_dior,
   input  logic                  ide_diow,
   input  logic [1:0]            ide_cs,
   input  logic [2:0]            ide_da,
   input  logic [15:0]           ide_data_in,
   output logic [15:0]           ide_data_out,
   output logic                  ide_data_oe,
   output logic [LBA_BITS+7:0]   mem_addr,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [15:0]           mem_wdata,
   input  logic [15:0]           mem_rdata,
   input  logic                  mem_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_FETCH,
      S_RD_DRQ,
      S_WR_DRQ,
      S_WR_STORE
   } state_e;

   state_e      state_q, state_d;
   logic        rd_act_q, wr_act_q;
   logic [2:0]  rd_da_q, wr_da_q;
   logic [15:0] wr_data_q;
   logic [15:0] rdata_q, rdata_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] dout_q;
   logic        oe_q;
   logic [8:0]  sec_cnt_q, sec_cnt_d;
   logic [27:0] lba_q, lba_d;
   logic [3:0]  dh_hi_q, dh_hi_d;
   logic [7:0]  word_idx_q, word_idx_d;
   logic [7:0]  error_q, error_d;
   logic        err_q, err_d;

   logic        cs_ok, rd_act, wr_act, rd_rise, wr_rise;
   logic        bsy, drq, wrap, last_word;
   logic [7:0]  status;
   logic [15:0] rd_word;

   assign cs_ok   = (ide_cs == 2'b10);
   assign rd_act  = cs_ok & ~ide_dior;
   assign wr_act  = cs_ok & ~ide_diow;
   assign rd_rise = rd_act_q & ~rd_act;
   assign wr_rise = wr_act_q & ~wr_act;

   assign bsy    = (state_q == S_RD_FETCH) || (state_q == S_WR_STORE);
   assign drq    = (state_q == S_RD_DRQ)   || (state_q == S_WR_DRQ);
   assign status = {bsy, 1'b1, 1'b0, 1'b1, drq, 2'b00, err_q};

   // The word about to complete closes the whole transfer when it ends the
   // final sector.
   assign wrap      = (word_idx_q == 8'hFF);
   assign last_word = wrap && (sec_cnt_q == 9'd1);

   assign ide_data_out = dout_q;
   assign ide_data_oe  = oe_q;
   assign mem_addr     = {lba_q[LBA_BITS-1:0], word_idx_q};
   assign mem_wdata    = wdata_q;

   // Read mux over the register captured while the strobe was low
   always_comb begin
      rd_word = 16'h0000;
      case (rd_da_q)
         3'd0:    rd_word = (state_q == S_RD_DRQ) ? rdata_q : 16'h0000;
         3'd1:    rd_word = {8'h00, error_q};
         3'd2:    rd_word = {8'h00, sec_cnt_q[7:0]};
         3'd3:    rd_word = {8'h00, lba_q[7:0]};
         3'd4:    rd_word = {8'h00, lba_q[15:8]};
         3'd5:    rd_word = {8'h00, lba_q[23:16]};
         3'd6:    rd_word = {8'h00, dh_hi_q, lba_q[27:24]};
         default: rd_word = {8'h00, status};
      endcase
   end

   // Next-state and request logic
   always_comb begin
      state_d    = state_q;
      sec_cnt_d  = sec_cnt_q;
      lba_d      = lba_q;
      dh_hi_d    = dh_hi_q;
      word_idx_d = word_idx_q;
      error_d    = error_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      wdata_d    = wdata_q;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;

      if (wr_rise && (state_q == S_IDLE)) begin
         case (wr_da_q)
            3'd2:    sec_cnt_d = {1'b0, wr_data_q[7:0]};
            3'd3:    lba_d[7:0]   = wr_data_q[7:0];
            3'd4:    lba_d[15:8]  = wr_data_q[7:0];
            3'd5:    lba_d[23:16] = wr_data_q[7:0];
            3'd6: begin
               dh_hi_d       = wr_data_q[7:4];
               lba_d[27:24]  = wr_data_q[3:0];
            end
            default: ;
         endcase
      end

      case (state_q)
         S_IDLE: begin
            if (wr_rise && (wr_da_q == 3'd7)) begin
               if ((wr_data_q[7:0] == 8'h20) || (wr_data_q[7:0] == 8'h30)) begin
                  err_d      = 1'b0;
                  error_d    = 8'h00;
                  sec_cnt_d  = (sec_cnt_q == 9'd0) ? 9'd256 : sec_cnt_q;
                  word_idx_d = 8'h00;
                  state_d    = (wr_data_q[7:0] == 8'h20) ? S_RD_FETCH : S_WR_DRQ;
               end else begin
                  err_d   = 1'b1;
                  error_d = 8'h04;
               end
            end
         end
         S_RD_FETCH: begin
            mem_rd = 1'b1;
            if (mem_done) begin
               rdata_d = mem_rdata;
               state_d = S_RD_DRQ;
            end
         end
         S_RD_DRQ: begin
            if (rd_rise && (rd_da_q == 3'd0)) begin
               word_idx_d = word_idx_q + 8'd1;
               if (wrap) begin
                  sec_cnt_d = sec_cnt_q - 9'd1;
                  lba_d     = lba_q + 28'd1;
               end
               state_d = last_word ? S_IDLE : S_RD_FETCH;
            end
         end
         S_WR_DRQ: begin
            if (wr_rise && (wr_da_q == 3'd0)) begin
               wdata_d = wr_data_q;
               state_d = S_WR_STORE;
            end
         end
         S_WR_STORE: begin
            mem_wr = 1'b1;
            if (mem_done) begin
               word_idx_d = word_idx_q + 8'd1;
               if (wrap) begin
                  sec_cnt_d = sec_cnt_q - 9'd1;
                  lba_d     = lba_q + 28'd1;
               end
               state_d = last_word ? S_IDLE : S_WR_DRQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Register stage: strobe sampling, task file, read-data output
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rd_act_q   <= 1'b0;
         wr_act_q   <= 1'b0;
         rd_da_q    <= 3'd0;
         wr_da_q    <= 3'd0;
         wr_data_q  <= 16'h0000;
         rdata_q    <= 16'h0000;
         wdata_q    <= 16'h0000;
         dout_q     <= 16'h0000;
         oe_q       <= 1'b0;
         sec_cnt_q  <= 9'd0;
         lba_q      <= 28'd0;
         dh_hi_q    <= 4'd0;
         word_idx_q <= 8'd0;
         error_q    <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_act_q   <= rd_act;
         wr_act_q   <= wr_act;
         // A read overlapping a write is answered with status and has no
         // data-port side effect.
         if (rd_act) rd_da_q <= wr_act ? 3'd7 : ide_da;
         if (wr_act) begin
            wr_da_q   <= ide_da;
            wr_data_q <= ide_data_in;
         end
         rdata_q    <= rdata_d;
         wdata_q    <= wdata_d;
         dout_q     <= rd_act_q ? rd_word : 16'h0000;
         oe_q       <= rd_act_q;
         sec_cnt_q  <= sec_cnt_d;
         lba_q      <= lba_d;
         dh_hi_q    <= dh_hi_d;
         word_idx_q <= word_idx_d;
         error_q    <= error_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_ide_disk_model.sv
module tb_ide_disk_model;
   localparam int LBA_BITS = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        ide_dior, ide_diow;
   logic [1:0]  ide_cs;
   logic [2:0]  ide_da;
   logic [15:0] ide_data_in, ide_data_out;
   logic        ide_data_oe;
   logic [15:0] mem_addr;
   logic        mem_rd, mem_wr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        mem_done, done_resp, done_force;
   logic        auto_mem;

   int checks = 0;
   int errors = 0;

   logic [15:0] store [0:65535];
   logic [15:0] rd_log[$];
   logic [15:0] wa_log[$];
   logic [15:0] wd_log[$];

   assign mem_done = done_resp | done_force;

   ide_disk_model #(.LBA_BITS(LBA_BITS)) dut (
      .clk(clk), .reset(reset),
      .ide_dior(ide_dior), .ide_diow(ide_diow), .ide_cs(ide_cs), .ide_da(ide_da),
      .ide_data_in(ide_data_in), .ide_data_out(ide_data_out), .ide_data_oe(ide_data_oe),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done)
   );

   always #5 clk = ~clk;

   // Backing store: services held requests after a random 0-2 cycle wait
   initial begin : responder
      int wt;
      wt = 0;
      done_resp = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         if (done_resp) begin
            done_resp = 1'b0;
            wt = $urandom_range(0, 2);
         end else if (auto_mem && (mem_rd || mem_wr)) begin
            if (wt > 0) wt--;
            else begin
               done_resp = 1'b1;
               if (mem_rd) begin
                  mem_rdata = store[mem_addr];
                  rd_log.push_back(mem_addr);
               end else begin
                  store[mem_addr] = mem_wdata;
                  wa_log.push_back(mem_addr);
                  wd_log.push_back(mem_wdata);
               end
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Host cycles start and end one time unit after a rising edge.
   task automatic host_read(input logic [2:0] da, output logic [15:0] d);
      ide_cs = 2'b10; ide_da = da; ide_dior = 1'b0;
      repeat (3) @(posedge clk);
      #1 d = ide_data_out;
      chk("oe", {31'b0, ide_data_oe}, 32'd1);
      ide_dior = 1'b1;
      @(posedge clk);
      #1 ide_cs = 2'b11;
   endtask

   task automatic host_write(input logic [2:0] da, input logic [15:0] d);
      ide_cs = 2'b10; ide_da = da; ide_data_in = d; ide_diow = 1'b0;
      repeat (3) @(posedge clk);
      #1 ide_diow = 1'b1;
      @(posedge clk);
      #1 ide_cs = 2'b11;
   endtask

   task automatic setup(input logic [27:0] lba, input logic [7:0] cnt);
      host_write(3'd2, {8'h00, cnt});
      host_write(3'd3, {8'h00, lba[7:0]});
      host_write(3'd4, {8'h00, lba[15:8]});
      host_write(3'd5, {8'h00, lba[23:16]});
      host_write(3'd6, {12'h000, lba[27:24]});
   endtask

   // Mid-transfer the status is either busy (D0) or data-request (58).
   task automatic wait_drq(output bit ok);
      logic [15:0] s;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         host_read(3'd7, s);
         if (s[3]) begin
            chk("drq_status", s, 32'h0058);
            ok = 1'b1;
            break;
         end
         chk("busy_status", s, 32'h00D0);
      end
      if (!ok) chk("drq_timeout", {31'b0, ok}, 32'd1);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      logic [15:0] v, ea;
      logic [15:0] hd [512];
      logic [27:0] lba_r, lba_n;
      logic [7:0]  rb;
      bit ok;

      for (int i = 0; i < 65536; i++) store[i] = 16'($urandom);
      reset = 1'b1; ide_dior = 1'b1; ide_diow = 1'b1; ide_cs = 2'b11;
      ide_da = 3'd0; ide_data_in = 16'h0000; done_force = 1'b0; auto_mem = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      chk("rst_dout", {16'h0, ide_data_out}, 32'h0);
      chk("rst_oe", {31'b0, ide_data_oe}, 32'h0);
      chk("rst_req", {30'b0, mem_rd, mem_wr}, 32'h0);
      chk("rst_addr", {16'h0, mem_addr}, 32'h0);
      chk("rst_wdata", {16'h0, mem_wdata}, 32'h0);
      host_read(3'd7, v); chk("rst_status", v, 32'h0050);
      host_read(3'd1, v); chk("rst_error", v, 32'h0000);
      host_read(3'd2, v); chk("rst_count", v, 32'h0000);

      // Register write/readback
      rb = 8'($urandom);
      host_write(3'd3, 16'hFF5A);
      host_write(3'd4, 16'h003C);
      host_write(3'd5, {8'h00, rb});
      host_read(3'd3, v); chk("reg3", v, 32'h005A);
      host_read(3'd4, v); chk("reg4", v, 32'h003C);
      host_read(3'd5, v); chk("reg5", v, {24'h0, rb});

      // Data port outside a transfer
      host_write(3'd0, 16'h1234);
      host_read(3'd0, v); chk("idle_data", v, 32'h0000);
      host_read(3'd7, v); chk("idle_status", v, 32'h0050);

      // Read and write strobes together: write lands, read returns status
      ide_cs = 2'b10; ide_da = 3'd3; ide_data_in = 16'h0077;
      ide_dior = 1'b0; ide_diow = 1'b0;
      repeat (3) @(posedge clk);
      #1 v = ide_data_out;
      ide_dior = 1'b1; ide_diow = 1'b1;
      @(posedge clk);
      #1 ide_cs = 2'b11;
      chk("both_status", v, 32'h0050);
      host_read(3'd3, v); chk("both_write", v, 32'h0077);

      // Unsupported command aborts without touching the store
      rd_log.delete(); wa_log.delete();
      host_write(3'd7, 16'h00EC);
      host_read(3'd7, v); chk("abrt_status", v, 32'h0051);
      host_read(3'd1, v); chk("abrt_error", v, 32'h0004);
      chk("abrt_req", {30'b0, mem_rd, mem_wr}, 32'h0);
      chk("abrt_mem", rd_log.size() + wa_log.size(), 32'd0);

      // READ SECTORS, LBA 5, one sector; also clears the abort
      setup(28'd5, 8'd1);
      rd_log.delete();
      host_write(3'd7, 16'h0020);
      for (int k = 0; k < 256; k++) begin
         wait_drq(ok);
         if (!ok) break;
         host_read(3'd0, v);
         ea = {8'(8'h05 + k / 256), 8'(k)};
         chk("rd_word", v, {16'h0, store[ea]});
      end
      host_read(3'd7, v); chk("rd_final_status", v, 32'h0050);
      host_read(3'd3, v); chk("rd_final_lba", v, 32'h0006);
      host_read(3'd1, v); chk("rd_error_clr", v, 32'h0000);
      chk("rd_count", rd_log.size(), 32'd256);
      if (rd_log.size() == 256) begin
         chk("rd_first_addr", {16'h0, rd_log[0]}, 32'h0500);
         chk("rd_last_addr", {16'h0, rd_log[255]}, 32'h05FF);
      end

      // WRITE SECTORS, LBA FF, two sectors, wrapping the forwarded LBA bits
      for (int k = 0; k < 512; k++) hd[k] = 16'($urandom);
      setup(28'h00000FF, 8'd2);
      wa_log.delete(); wd_log.delete();
      host_write(3'd7, 16'h0030);
      for (int k = 0; k < 512; k++) begin
         wait_drq(ok);
         if (!ok) break;
         host_write(3'd0, hd[k]);
      end
      for (int i = 0; i < 10 && mem_wr; i++) @(posedge clk);
      #1;
      host_read(3'd7, v); chk("wr_final_status", v, 32'h0050);
      host_read(3'd2, v); chk("wr_final_count", v, 32'h0000);
      chk("wr_count", wa_log.size(), 32'd512);
      for (int k = 0; k < 512 && k < wa_log.size(); k++) begin
         ea = {8'(8'hFF + k / 256), 8'(k)};
         chk("wr_addr", {16'h0, wa_log[k]}, {16'h0, ea});
         chk("wr_data", {16'h0, wd_log[k]}, {16'h0, hd[k]});
      end

      // Count 0 means 256 sectors: run the first sector and inspect progress
      lba_r = 28'($urandom);
      lba_n = lba_r + 28'd1;
      setup(lba_r, 8'd0);
      host_write(3'd7, 16'h0020);
      for (int k = 0; k < 256; k++) begin
         wait_drq(ok);
         if (!ok) break;
         host_read(3'd0, v);
         ea = {lba_r[7:0], 8'(k)};
         chk("big_word", v, {16'h0, store[ea]});
      end
      host_read(3'd2, v); chk("big_count", v, 32'h00FF);
      host_read(3'd3, v); chk("big_lba0", v, {24'h0, lba_n[7:0]});
      host_read(3'd4, v); chk("big_lba1", v, {24'h0, lba_n[15:8]});
      host_read(3'd6, v); chk("big_lba3", v, {28'h0, lba_n[27:24]});
      host_write(3'd3, 16'h0099);
      host_write(3'd7, 16'h00EC);
      host_read(3'd3, v); chk("busy_reg_write", v, {24'h0, lba_n[7:0]});
      host_read(3'd7, v); chk("busy_cmd_ignored", {31'b0, v[0]}, 32'h0);
      pulse_reset();

      // Reset during a fetch, completion arriving afterwards is ignored
      auto_mem = 1'b0;
      setup(28'd3, 8'd1);
      host_write(3'd7, 16'h0020);
      chk("fetch_req", {31'b0, mem_rd}, 32'd1);
      pulse_reset();
      done_force = 1'b1;
      @(posedge clk);
      #1 done_force = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mid_req", {30'b0, mem_rd, mem_wr}, 32'h0);
      host_read(3'd7, v); chk("rst_mid_status", v, 32'h0050);
      host_read(3'd3, v); chk("rst_mid_lba", v, 32'h0000);
      host_read(3'd0, v); chk("rst_mid_data", v, 32'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ide_disk_model.md
# ide_disk_model

- Device end of the IDE/ATA PIO bus that the PDP-8 I/O subsystem drives as host (`ide_dior`, `ide_diow`, `ide_cs`, `ide_da`, 16-bit data).
- Emulates a single LBA disk for simulation and for on-FPGA use without a physical drive.
- Sector data lives in a word-addressed backing store reached through a simple request/done port.
- Implements the ATA task file, READ SECTORS and WRITE SECTORS; every other command aborts.

## Interface
Parameters:
- LBA_BITS, 8, LBA bits forwarded to the backing store; mem_addr width is LBA_BITS+8.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ide_dior  in  1  read strobe, active-low.
- ide_diow  in  1  write strobe, active-low.
- ide_cs  in  2  chip selects, active-low; task file decoded only when ide_cs == 2'b10 (CS0 asserted); anything else is ignored.
- ide_da  in  3  task file register address.
- ide_data_in  in  16  host write data.
- ide_data_out  out  16  device read data.
- ide_data_oe  out  1  high while a decoded read strobe is low.
- mem_addr  out  LBA_BITS+8  {lba[LBA_BITS-1:0], word_idx[7:0]}.
- mem_rd  out  1  backing-store read request; held until mem_done.
- mem_wr  out  1  backing-store write request; held until mem_done.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data, valid in the mem_done cycle.
- mem_done  in  1  one-cycle completion pulse.

## Operation
Task file, selected by ide_da:
- 0: data.
- 1: error (read) / features (write, ignored).
- 2: sector count.
- 3–5: LBA[7:0], LBA[15:8], LBA[23:16].
- 6: drive/head; bits[3:0] = LBA[27:24].
- 7: status (read) / command (write).
- Byte registers return {8'h00, reg} on read and use ide_data_in[7:0] on write.

Status byte:
- bit7 BSY, bit6 DRDY (always 1), bit4 DSC (always 1), bit3 DRQ, bit0 ERR.

Strobe handling:
- Strobes are same-clock-domain; they are sampled every clk and edge-detected against a one-cycle-delayed copy.
- Write: ide_data_in is captured on every cycle the write strobe is low; the register updates on the diow rising edge using the last captured value.
- Read: side effects (data-word advance) occur on the dior rising edge.

States:
- IDLE
  - DRQ=0, BSY=0.
  - Command 8'h20 or 8'h30 clears ERR and error, loads sec_cnt (0 means 256; 9-bit counter) and lba, and sets word_idx=0.
  - 8'h20 goes to RD_FETCH; 8'h30 goes to WR_DRQ.
  - Any other opcode: error=8'h04 (ABRT), ERR=1, stay IDLE.
- RD_FETCH
  - BSY=1, mem_rd=1.
  - On mem_done: hold mem_rdata and go to RD_DRQ.
- RD_DRQ
  - DRQ=1; a data-register read returns the held word.
  - On the dior rising edge: word_idx++.
  - If word_idx wraps to 0: sec_cnt--, lba++.
  - Then go to IDLE if sec_cnt reached 0, else to RD_FETCH.
- WR_DRQ
  - DRQ=1.
  - Data-register write completes: latch the word into mem_wdata, go to WR_STORE.
- WR_STORE
  - BSY=1, mem_wr=1.
  - On mem_done: advance word_idx / sec_cnt / lba exactly as for reads, then go to IDLE or WR_DRQ.

Rules:
- lba arithmetic wraps modulo 2^28; only the low LBA_BITS go to mem_addr.
- Task-file registers 1–6 show live lba / sec_cnt[7:0] on read; they track as the transfer advances.
- Data-register access outside RD_DRQ/WR_DRQ: reads return 16'h0000, writes are discarded, no error.
- Command-register writes while not IDLE are ignored.
- Writes to registers 2–6 while not IDLE are ignored.

## Timing
Reset values:
- All task-file registers 0, status 8'h50, state IDLE.
- ide_data_out 0, ide_data_oe 0, mem_rd 0, mem_wr 0, mem_addr 0, mem_wdata 0.

Read and request timing:
- ide_data_out and ide_data_oe are registered: valid on the second clk edge after dior goes low, and remain valid while it is held. The host holds strobes ≥3 cycles.
- mem_rd / mem_wr assert on the first cycle of RD_FETCH / WR_STORE and drop in the cycle after mem_done.
- mem_addr is stable while a request is held.

Command and transfer timing:
- Command write to first mem_rd: 1 cycle after the diow rising edge is sampled.
- BSY is visible in status from the cycle the command is accepted; there is no window where BSY=0 and DRQ=0 mid-transfer.
- After the last word's advance, status returns to 8'h50 in the same cycle IDLE is entered.

Reset and simultaneous events:
- Reset mid-transfer: an outstanding request is abandoned, and mem_done arriving after reset is ignored. The next state is IDLE with reset values.
- Strobe edges coincident with reset are ignored.
- dior and diow low simultaneously: the write takes effect, the read returns status.

## Test plan
- Reset, then read status (da=7) -> 16'h0050; read error -> 16'h0000; mem_rd=mem_wr=0.
- Write 8'h5A to da=3, 8'h3C to da=4, then read back -> 16'h005A, 16'h003C.
- LBA=5, count=1, cmd 8'h20, backing store returns addr-derived data -> 256 mem_rd, first at mem_addr=16'h0500, last at 16'h05FF. Host reads match in order; final status 8'h50, da=3 reads 16'h0006.
- LBA=8'hFF, count=2, cmd 8'h30 -> 512 mem_wr with data equal to host data, addresses 16'hFF00–16'hFFFF then 16'h0000–16'h00FF (LBA_BITS wrap); final sector count reads 0.
- cmd 8'hEC -> status 8'h51, error 16'h0004, no mem activity. A following valid cmd 8'h20 clears ERR.
- count=0, cmd 8'h20 -> 65536 words before IDLE. Separately, reset asserted during RD_FETCH with mem_done one cycle later -> mem_rd low, status 8'h50, no DRQ.
